// File: rtl/bti_arb2_if.sv
// BTI request and response channels: valid/ready handshake carrying a packed packet.
// The master drives vld/pkt and the slave drives rdy.
interface bti_req_if_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        we;
    logic [3:0]  tid;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  tid;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_arb2.sv
// Two-requester BTI arbiter. Grants one requester at a time to a shared slave.
// The grant order is kept in a small source-id FIFO, so that in-order responses
// can be steered back to the requester that issued them.
module bti_arb2 #(
  parameter int OSTD_DEPTH = 2,
  parameter int FIXED_PRI  = 0
) (
  input  logic         clk,
  input  logic         rst,
  bti_req_if_t.slv     s0_req_slv,
  bti_rsp_if_t.mst     s0_rsp_mst,
  bti_req_if_t.slv     s1_req_slv,
  bti_rsp_if_t.mst     s1_rsp_mst,
  bti_req_if_t.mst     m_req_mst,
  bti_rsp_if_t.slv     m_rsp_slv,
  output logic         err_unexp_rsp
);
  localparam int CW = $clog2(OSTD_DEPTH) + 1;
  localparam int AW = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;

  logic                  rr_ptr;
  logic                  lock_vld, lock_sel;
  logic [OSTD_DEPTH-1:0] fifo_q;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic sel, hsel, full, empty, m_hs, rsp_hs, pop;

  // Pointer advance wraps explicitly so that non-trivial depths and depth 1 both work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OSTD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(OSTD_DEPTH));
  assign empty = (count == '0);
  assign hsel  = fifo_q[rd_ptr];

  // Grant select: a stalled grant stays locked, so that the downstream pkt is stable.
  always_comb begin
    sel = 1'b0;
    if (lock_vld)                          sel = lock_sel;
    else if (s0_req_slv.vld && !s1_req_slv.vld) sel = 1'b0;
    else if (s1_req_slv.vld && !s0_req_slv.vld) sel = 1'b1;
    else if (FIXED_PRI != 0)               sel = 1'b0;
    else                                   sel = rr_ptr;
  end

  // Request path: pure function of request-side state, so there is no path from responses.
  assign m_req_mst.vld  = !rst && (s0_req_slv.vld || s1_req_slv.vld) && !full;
  assign m_req_mst.pkt  = sel ? s1_req_slv.pkt : s0_req_slv.pkt;
  assign s0_req_slv.rdy = !rst && m_req_mst.rdy && !full && !sel;
  assign s1_req_slv.rdy = !rst && m_req_mst.rdy && !full &&  sel;
  assign m_hs           = m_req_mst.vld && m_req_mst.rdy;

  // Response path: steer to the FIFO head. A response with an empty FIFO is sunk.
  assign s0_rsp_mst.vld = !rst && !empty && !hsel && m_rsp_slv.vld;
  assign s1_rsp_mst.vld = !rst && !empty &&  hsel && m_rsp_slv.vld;
  assign s0_rsp_mst.pkt = m_rsp_slv.pkt;
  assign s1_rsp_mst.pkt = m_rsp_slv.pkt;
  assign m_rsp_slv.rdy  = !rst && (empty || (hsel ? s1_rsp_mst.rdy : s0_rsp_mst.rdy));
  assign rsp_hs         = m_rsp_slv.vld && m_rsp_slv.rdy;
  assign pop            = rsp_hs && !empty;

  // Arbitration state: round-robin pointer and the stall lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      lock_vld <= 1'b0;
      lock_sel <= 1'b0;
    end else begin
      if (m_hs && FIXED_PRI == 0) rr_ptr <= ~sel;
      if (m_req_mst.vld && !m_req_mst.rdy) begin
        lock_vld <= 1'b1;
        lock_sel <= sel;
      end else if (m_hs) begin
        lock_vld <= 1'b0;
      end
    end
  end

  // Outstanding-source FIFO: push on a request handshake, pop on a response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (m_hs) begin
        fifo_q[wr_ptr] <= sel;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (m_hs && !pop)      count <= count + 1'b1;
      else if (!m_hs && pop) count <= count - 1'b1;
    end
  end

  // A response with nothing outstanding sets a sticky error that only reset clears.
  always_ff @(posedge clk) begin
    if (rst)                          err_unexp_rsp <= 1'b0;
    else if (m_rsp_slv.vld && empty)  err_unexp_rsp <= 1'b1;
  end
endmodule

// File: tb/tb_bti_arb2.sv
// Directed bench for bti_arb2: a round-robin instance and a fixed-priority
// instance are driven with identical stimulus.
module tb_bti_arb2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_a, err_b;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  bti_req_if_t a0(), a1(), am();
  bti_rsp_if_t ap0(), ap1(), amp();
  bti_req_if_t b0(), b1(), bm();
  bti_rsp_if_t bp0(), bp1(), bmp();

  // The fixed-priority instance mirrors the stimulus of the round-robin one.
  assign b0.vld  = a0.vld;
  assign b0.pkt  = a0.pkt;
  assign b1.vld  = a1.vld;
  assign b1.pkt  = a1.pkt;
  assign bm.rdy  = am.rdy;
  assign bp0.rdy = ap0.rdy;
  assign bp1.rdy = ap1.rdy;
  assign bmp.vld = amp.vld;
  assign bmp.pkt = amp.pkt;

  bti_arb2 #(.OSTD_DEPTH(2), .FIXED_PRI(0)) dut_a (
    .clk(clk), .rst(rst),
    .s0_req_slv(a0), .s0_rsp_mst(ap0), .s1_req_slv(a1), .s1_rsp_mst(ap1),
    .m_req_mst(am), .m_rsp_slv(amp), .err_unexp_rsp(err_a));

  bti_arb2 #(.OSTD_DEPTH(2), .FIXED_PRI(1)) dut_b (
    .clk(clk), .rst(rst),
    .s0_req_slv(b0), .s0_rsp_mst(bp0), .s1_req_slv(b1), .s1_rsp_mst(bp1),
    .m_req_mst(bm), .m_rsp_slv(bmp), .err_unexp_rsp(err_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    a0.vld = 0; a0.pkt = '0; a1.vld = 0; a1.pkt = '0;
    am.rdy = 0; ap0.rdy = 1; ap1.rdy = 1; amp.vld = 0; amp.pkt = '0;

    // Reset: all handshake outputs held low, even with a request pending.
    a0.vld = 1; a0.pkt.addr = 32'h100; am.rdy = 1; amp.vld = 1;
    tick(); #1;
    chk("rst_mvld", am.vld, 0);
    chk("rst_s0rdy", a0.rdy, 0);
    chk("rst_p0vld", ap0.vld, 0);
    chk("rst_mrsprdy", amp.rdy, 0);
    chk("rst_err", err_a, 0);
    amp.vld = 0;
    tick();
    rst = 0;

    // Single requester, back-to-back reads with responses one cycle later.
    #1;
    chk("sgl_vld0", am.vld, 1);
    chk("sgl_addr0", am.pkt.addr, 32'h100);
    chk("sgl_rdy0", a0.rdy, 1);
    tick();
    a0.pkt.addr = 32'h104; amp.vld = 1; amp.pkt.rdata = 32'hA0; #1;
    chk("sgl_addr1", am.pkt.addr, 32'h104);
    chk("sgl_p0vld0", ap0.vld, 1);
    chk("sgl_p0dat0", ap0.pkt.rdata, 32'hA0);
    chk("sgl_p1vld0", ap1.vld, 0);
    tick();
    a0.vld = 0; amp.pkt.rdata = 32'hA1; #1;
    chk("sgl_p0vld1", ap0.vld, 1);
    chk("sgl_p0dat1", ap0.pkt.rdata, 32'hA1);
    chk("sgl_p1vld1", ap1.vld, 0);
    chk("sgl_mvld_idle", am.vld, 0);
    tick();
    amp.vld = 0;

    // Contention from reset: RR alternates 0,1,0,1; fixed priority always picks 0.
    rst = 1; tick(); rst = 0;
    a0.vld = 1; a0.pkt.addr = 32'h200; a1.vld = 1; a1.pkt.addr = 32'h300; #1;
    chk("rr_g0", am.pkt.addr, 32'h200);
    chk("fp_g0", bm.pkt.addr, 32'h200);
    tick();
    amp.vld = 1; #1;
    chk("rr_g1", am.pkt.addr, 32'h300);
    chk("rr_g1_rdy1", a1.rdy, 1);
    chk("fp_g1", bm.pkt.addr, 32'h200);
    chk("fp_g1_rdy1", b1.rdy, 0);
    tick(); #1;
    chk("rr_g2", am.pkt.addr, 32'h200);
    chk("fp_g2", bm.pkt.addr, 32'h200);
    tick(); #1;
    chk("rr_g3", am.pkt.addr, 32'h300);
    chk("fp_g3", bm.pkt.addr, 32'h200);
    chk("fp_g3_rdy1", b1.rdy, 0);
    tick();
    a0.vld = 0; a1.vld = 0;
    tick();
    amp.vld = 0;

    // Stall lock: s1 stalled three cycles, s0 arrives meanwhile but must wait.
    rst = 1; tick(); rst = 0;
    a1.vld = 1; am.rdy = 0; #1;
    chk("lk_c1", am.pkt.addr, 32'h300);
    tick();
    a0.vld = 1; #1;
    chk("lk_c2", am.pkt.addr, 32'h300);
    chk("lk_c2_rdy0", a0.rdy, 0);
    tick(); #1;
    chk("lk_c3", am.pkt.addr, 32'h300);
    tick();
    am.rdy = 1; #1;
    chk("lk_c4", am.pkt.addr, 32'h300);
    chk("lk_c4_rdy1", a1.rdy, 1);
    chk("lk_c4_rdy0", a0.rdy, 0);
    tick();
    a1.vld = 0; #1;
    chk("lk_c5", am.pkt.addr, 32'h200);
    chk("lk_c5_rdy0", a0.rdy, 1);
    tick();

    // Full: two outstanding (s1 then s0), a new request must wait for a pop.
    a0.pkt.addr = 32'h204; #1;
    chk("full_mvld", am.vld, 0);
    chk("full_rdy0", a0.rdy, 0);
    chk("full_rdy1", a1.rdy, 0);
    amp.vld = 1; amp.pkt.rdata = 32'hD0; #1;
    chk("full_p1vld", ap1.vld, 1);
    chk("full_mrsprdy", amp.rdy, 1);
    chk("full_mvld_pop", am.vld, 0);
    tick();
    amp.vld = 0; #1;
    chk("full_issue_vld", am.vld, 1);
    chk("full_issue_addr", am.pkt.addr, 32'h204);
    tick();
    a0.vld = 0; amp.vld = 1; #1;
    chk("full_dr0", ap0.vld, 1);
    tick(); #1;
    chk("full_dr1", ap0.vld, 1);
    tick();
    amp.vld = 0;

    // Interleaved routing: s0 write, s1 read, s0 read; responses A, B, C.
    a0.vld = 1; a0.pkt.addr = 32'h10; a0.pkt.we = 1; a0.pkt.strb = 4'hF; #1;
    chk("il_we", {27'b0, am.pkt.we, am.pkt.strb}, 32'h1F);
    tick();
    a0.vld = 0; a0.pkt.we = 0; a0.pkt.strb = 0; a1.vld = 1; a1.pkt.addr = 32'h20; #1;
    chk("il_addr1", am.pkt.addr, 32'h20);
    tick();
    a1.vld = 0; a0.vld = 1; a0.pkt.addr = 32'h30; amp.vld = 1; amp.pkt.rdata = 32'hA; #1;
    chk("il_full", am.vld, 0);
    chk("il_rA_p0", ap0.vld, 1);
    chk("il_rA_dat", ap0.pkt.rdata, 32'hA);
    chk("il_rA_p1", ap1.vld, 0);
    tick();
    ap1.rdy = 0; amp.pkt.rdata = 32'hB; #1;
    chk("il_addr2", am.pkt.addr, 32'h30);
    chk("il_bp0_p1", ap1.vld, 1);
    chk("il_bp0_rdy", amp.rdy, 0);
    tick();
    a0.vld = 0; #1;
    chk("il_bp1_rdy", amp.rdy, 0);
    chk("il_bp1_p1", ap1.vld, 1);
    chk("il_bp1_p0", ap0.vld, 0);
    tick();
    ap1.rdy = 1; #1;
    chk("il_rB_rdy", amp.rdy, 1);
    chk("il_rB_dat", ap1.pkt.rdata, 32'hB);
    tick();
    amp.pkt.rdata = 32'hC; #1;
    chk("il_rC_p0", ap0.vld, 1);
    chk("il_rC_dat", ap0.pkt.rdata, 32'hC);
    chk("il_rC_p1", ap1.vld, 0);
    tick();

    // Unexpected response with nothing outstanding: sunk, error sticks.
    #1;
    chk("ux_rdy", amp.rdy, 1);
    chk("ux_p0", ap0.vld, 0);
    chk("ux_p1", ap1.vld, 0);
    chk("ux_err_pre", err_a, 0);
    tick();
    amp.vld = 0; #1;
    chk("ux_err", err_a, 1);
    tick(); #1;
    chk("ux_err_sticky", err_a, 1);

    // Reset with two outstanding discards everything.
    a0.vld = 1; a0.pkt.addr = 32'h400;
    tick(); tick();
    chk("rs_cnt_pre", 32'(dut_a.count), 2);
    rst = 1;
    tick(); #1;
    chk("rs_cnt", 32'(dut_a.count), 0);
    chk("rs_err", err_a, 0);
    chk("rs_mvld", am.vld, 0);
    chk("rs_p0", ap0.vld, 0);
    chk("rs_p1", ap1.vld, 0);
    a0.vld = 0; rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
